// File: rtl/codegen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codegen_pkg
// Description : Shared types for the multi-mode code generator: the
//               generation-mode encoding and the control FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package codegen_pkg;

  // Encoding matches the 2-bit mode input of codegen_multi.
  typedef enum logic [1:0] {
    MODE_INC  = 2'd0,
    MODE_DEC  = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_GRAY = 2'd3
  } mode_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage : codegen_pkg
`default_nettype wire

// File: rtl/codegen_step.sv
`default_nettype none
// ============================================================================
// Module      : codegen_step
// Description : Combinational next-code generator for all four modes.
//               Given the current code (and the binary shadow counter used by
//               Gray mode) it returns the next code and whether producing it
//               wrapped around the configured range.
// Ports       : mode_i       generation mode
//               data_i       current output code
//               bin_i        current binary counter (Gray mode source)
//               seed_i       lower bound / restart value
//               step_i       increment for INC/DEC/GRAY
//               limit_i      upper bound for INC/DEC/GRAY
//               next_data_o  next output code
//               next_bin_o   next binary counter value
//               wrap_o       next value came from a wrap
// Revision    : 1.0 - initial release
// ============================================================================
module codegen_step
  import codegen_pkg::*;
#(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   TAPS  = 8'hB8
) (
  input  mode_t              mode_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [WIDTH-1:0]   bin_i,
  input  logic [WIDTH-1:0]   seed_i,
  input  logic [WIDTH-1:0]   step_i,
  input  logic [WIDTH-1:0]   limit_i,
  output logic [WIDTH-1:0]   next_data_o,
  output logic [WIDTH-1:0]   next_bin_o,
  output logic               wrap_o
);

  // One extra bit so that sums past 2**WIDTH-1 compare correctly against limit.
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_bsum;
  logic [WIDTH:0] w_floor;

  assign w_sum   = {1'b0, data_i} + {1'b0, step_i};
  assign w_bsum  = {1'b0, bin_i}  + {1'b0, step_i};
  assign w_floor = {1'b0, seed_i} + {1'b0, step_i};

  always_comb begin
    next_data_o = data_i;
    next_bin_o  = bin_i;
    wrap_o      = 1'b0;
    case (mode_i)
      MODE_INC: begin
        if (w_sum > {1'b0, limit_i}) begin
          next_data_o = seed_i;
          wrap_o      = 1'b1;
        end else begin
          next_data_o = w_sum[WIDTH-1:0];
        end
        next_bin_o = next_data_o;
      end
      MODE_DEC: begin
        // Stepping down would go below seed: restart from the top.
        if ({1'b0, data_i} < w_floor) begin
          next_data_o = limit_i;
          wrap_o      = 1'b1;
        end else begin
          next_data_o = data_i - step_i;
        end
        next_bin_o = next_data_o;
      end
      MODE_LFSR: begin
        // Galois form: shift right, fold taps in when a one falls out.
        if (data_i[0]) begin
          next_data_o = (data_i >> 1) ^ TAPS;
        end else begin
          next_data_o = data_i >> 1;
        end
        next_bin_o = next_data_o;
      end
      MODE_GRAY: begin
        // Range and wrap are evaluated on the binary counter; output is its Gray code.
        if (w_bsum > {1'b0, limit_i}) begin
          next_bin_o = seed_i;
          wrap_o     = 1'b1;
        end else begin
          next_bin_o = w_bsum[WIDTH-1:0];
        end
        next_data_o = next_bin_o ^ (next_bin_o >> 1);
      end
      default: begin
        next_data_o = data_i;
        next_bin_o  = bin_i;
        wrap_o      = 1'b0;
      end
    endcase
  end

endmodule : codegen_step
`default_nettype wire

// File: rtl/codegen_multi.sv
`default_nettype none
// ============================================================================
// Module      : codegen_multi
// Description : Multi-mode code stream generator (INC / DEC / LFSR / Gray)
//               with programmable seed, step, limit and burst length, and a
//               valid/ready output handshake.
// Ports       : clk, rst      clock, asynchronous active-high reset
//               start         latch config and begin a burst (IDLE only)
//               stop          abort the running burst
//               mode, seed, step, limit, burst_len   burst configuration
//               data, valid   output code and its qualifier
//               ready         consumer accept
//               busy          burst in progress
//               done          one-cycle pulse after the last word of a burst
//               wrap          high on an accept whose successor wrapped
// Revision    : 1.0 - initial release
// ============================================================================
module codegen_multi
  import codegen_pkg::*;
#(
  parameter int                 WIDTH   = 8,
  parameter int                 BURST_W = 16,
  parameter logic [WIDTH-1:0]   TAPS    = 8'hB8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     seed,
  input  logic [WIDTH-1:0]     step,
  input  logic [WIDTH-1:0]     limit,
  input  logic [BURST_W-1:0]   burst_len,
  output logic [WIDTH-1:0]     data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 wrap
);

  state_t               state_q, state_d;
  mode_t                mode_q;
  logic [WIDTH-1:0]     seed_q, step_q, limit_q;
  logic [BURST_W-1:0]   len_q;
  logic [BURST_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [WIDTH-1:0]     bin_q, bin_d;
  logic                 done_q, done_d;

  logic                 w_load;
  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_next_data;
  logic [WIDTH-1:0]     w_next_bin;
  logic                 w_step_wrap;
  logic [WIDTH-1:0]     w_first;

  assign w_load   = (state_q == S_IDLE) && start;
  assign w_accept = (state_q == S_RUN) && ready;
  assign w_last   = (len_q != '0) && (count_q == len_q - BURST_W'(1));

  // First word: LFSR cannot start from the all-zero lock-up state, and Gray
  // mode presents the Gray encoding of the binary seed.
  always_comb begin
    w_first = seed;
    if ((mode_t'(mode) == MODE_LFSR) && (seed == '0)) begin
      w_first = WIDTH'(1);
    end else if (mode_t'(mode) == MODE_GRAY) begin
      w_first = seed ^ (seed >> 1);
    end
  end

  codegen_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .mode_i      (mode_q),
    .data_i      (data_q),
    .bin_i       (bin_q),
    .seed_i      (seed_q),
    .step_i      (step_q),
    .limit_i     (limit_q),
    .next_data_o (w_next_data),
    .next_bin_o  (w_next_bin),
    .wrap_o      (w_step_wrap)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    bin_d   = bin_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          count_d = '0;
          data_d  = w_first;
          bin_d   = (mode_t'(mode) == MODE_GRAY) ? seed : w_first;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          data_d  = w_next_data;
          bin_d   = w_next_bin;
          count_d = count_q + BURST_W'(1);
          if (w_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        // An accept in the same cycle still completes above; stop only ends the burst.
        if (stop) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      data_q  <= '0;
      bin_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      bin_q   <= bin_d;
      done_q  <= done_d;
    end
  end

  // Configuration is captured only when a burst starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_INC;
      seed_q  <= '0;
      step_q  <= '0;
      limit_q <= '0;
      len_q   <= '0;
    end else if (w_load) begin
      mode_q  <= mode_t'(mode);
      seed_q  <= seed;
      step_q  <= step;
      limit_q <= limit;
      len_q   <= burst_len;
    end
  end

  assign data  = data_q;
  assign valid = (state_q == S_RUN);
  assign busy  = (state_q == S_RUN);
  assign done  = done_q;
  assign wrap  = w_accept && w_step_wrap;

endmodule : codegen_multi
`default_nettype wire

// File: tb/tb_codegen_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_codegen_multi
// Description : Scoreboard bench for codegen_multi. Stimulus pushes expected
//               words into a queue; a negedge monitor pops one per accept.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_codegen_multi;

  localparam int W  = 8;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          rst, start, stop, ready;
  logic [1:0]    mode;
  logic [W-1:0]  seed, step, limit;
  logic [BW-1:0] burst_len;
  logic [W-1:0]  data;
  logic          valid, busy, done, wrap;

  typedef struct {
    logic [W-1:0] d;
    logic         w;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  codegen_multi #(.WIDTH(W), .BURST_W(BW), .TAPS(8'hB8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .seed      (seed),
    .step      (step),
    .limit     (limit),
    .burst_len (burst_len),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic w);
    exp_t e;
    e.d = d;
    e.w = w;
    exp_q.push_back(e);
  endtask

  function automatic logic [W-1:0] lfsr_nx(input logic [W-1:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  // Monitor: every accepted word must match the head of the queue; a stalled
  // word must equal the head without consuming it.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {24'd0, data}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data", {24'd0, data}, {24'd0, e.d});
          check("wrap", {31'd0, wrap}, {31'd0, e.w});
        end
      end else if (valid && exp_q.size() != 0) begin
        check("data_hold", {24'd0, data}, {24'd0, exp_q[0].d});
      end
    end
  end

  // Runs one burst starting at posedge+1. Finishes at posedge+1 two cycles
  // after the final accept.
  task automatic run_burst(input logic [1:0] m, input logic [W-1:0] sd, input logic [W-1:0] st,
                           input logic [W-1:0] lim, input logic [BW-1:0] len, input int n_acc,
                           input bit use_stop, input bit toggle_rdy, input bit mid_start,
                           input bit exp_done);
    int k   = 0;
    int cyc = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    mode = m; seed = sd; step = st; limit = lim; burst_len = len;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("valid_after_start", {31'd0, valid}, 32'd1);
    while (k < n_acc && cyc < 2000) begin
      ready = toggle_rdy ? pat[cyc % 4] : 1'b1;
      if (mid_start && cyc == 2) start = 1'b1;
      if (valid && ready) begin
        k++;
        if (use_stop && k == n_acc) stop = 1'b1;
      end
      @(posedge clk); #1;
      stop  = 1'b0;
      start = 1'b0;
      cyc++;
    end
    if (k < n_acc) check("burst_timeout", k, n_acc);
    check("done_pulse", {31'd0, done}, {31'd0, exp_done});
    check("valid_after_end", {31'd0, valid}, 32'd0);
    check("busy_after_end", {31'd0, busy}, 32'd0);
    ready = 1'b1;
    @(posedge clk); #1;
    check("done_clear", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] v;
    int k;
    rst = 1'b1; start = 1'b0; stop = 1'b0; ready = 1'b1;
    mode = 2'd0; seed = '0; step = '0; limit = '0; burst_len = '0;

    #12;
    check("rst_data",  {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_wrap",  {31'd0, wrap}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // INC: 3,5,7,9 then 11>9 wraps to seed.
    push(8'd3, 0); push(8'd5, 0); push(8'd7, 0); push(8'd9, 1); push(8'd3, 0); push(8'd5, 0);
    run_burst(2'd0, 8'd3, 8'd2, 8'd9, 16'd6, 6, 0, 0, 0, 1);

    // DEC: first word is the seed 2; 2 < 2+3 wraps straight to limit.
    push(8'd2, 1); push(8'd10, 0); push(8'd7, 0); push(8'd4, 1); push(8'd10, 0);
    run_burst(2'd1, 8'd2, 8'd3, 8'd10, 16'd5, 5, 0, 0, 0, 1);

    // GRAY: binary 0..7 encoded, wrap when binary 7 -> 8 > limit.
    push(8'h0, 0); push(8'h1, 0); push(8'h3, 0); push(8'h2, 0); push(8'h6, 0);
    push(8'h7, 0); push(8'h5, 0); push(8'h4, 1); push(8'h0, 0);
    run_burst(2'd3, 8'd0, 8'd1, 8'd7, 16'd9, 9, 0, 0, 0, 1);

    // INC with ready pattern 1,0,0,1 and a start pulse mid-burst that must be ignored.
    push(8'd10, 0); push(8'd15, 0); push(8'd20, 1); push(8'd10, 0); push(8'd15, 0);
    run_burst(2'd0, 8'd10, 8'd5, 8'd20, 16'd5, 5, 0, 1, 1, 1);

    // step 0 repeats the seed; seed == limit does not wrap.
    push(8'd4, 0); push(8'd4, 0); push(8'd4, 0);
    run_burst(2'd0, 8'd4, 8'd0, 8'd4, 16'd3, 3, 0, 0, 0, 1);

    // Single-word burst.
    push(8'd7, 0);
    run_burst(2'd0, 8'd7, 8'd1, 8'd9, 16'd1, 1, 0, 0, 0, 1);

    // LFSR from seed 0 loads 01; continuous until stop after 260 words (period 255).
    v = 8'h01;
    for (int i = 0; i < 260; i++) begin
      push(v, 0);
      v = lfsr_nx(v);
    end
    run_burst(2'd2, 8'd0, 8'd0, 8'd0, 16'd0, 260, 1, 0, 0, 0);
    check("data_kept_after_stop", {24'd0, data}, {24'd0, v});

    // Asynchronous reset mid-burst.
    push(8'd0, 0); push(8'd1, 0); push(8'd2, 0);
    mode = 2'd0; seed = 8'd0; step = 8'd1; limit = 8'd255; burst_len = 16'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 100 && k < 3; c++) begin
      if (valid && ready) k++;
      @(posedge clk); #1;
    end
    ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_data",  {24'd0, data}, 32'd0);
    check("async_rst_valid", {31'd0, valid}, 32'd0);
    check("async_rst_busy",  {31'd0, busy}, 32'd0);
    check("async_rst_done",  {31'd0, done}, 32'd0);
    check("async_rst_accepts", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_done",  {31'd0, done}, 32'd0);
    check("post_rst_valid", {31'd0, valid}, 32'd0);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_codegen_multi
`default_nettype wire
